// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit datapaths.
package uart_pkg;

    localparam int UART_WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic eight;
        logic pen;
        logic ohel;
    } rx_cfg_t;

    // Error when the XOR over data and parity bit disagrees with the requested sense.
    function automatic logic parity_err(
        input logic [UART_WORD_W-1:0] data,
        input logic                   pbit,
        input rx_cfg_t                cfg
    );
        return cfg.pen & ((^data ^ pbit) != cfg.ohel);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Host-side result/handshake bundle of the UART receive controller.
interface uart_rx_frame_ctrl_if;
    import uart_pkg::*;

    logic [UART_WORD_W-1:0] rx_data;
    logic                   rxrdy;
    logic                   perr;
    logic                   ferr;
    logic                   ovf;
    logic                   busy;
    logic                   rd_ack;

    modport master (
        output rx_data, rxrdy, perr, ferr, ovf, busy,
        input  rd_ack
    );

    modport slave (
        input  rx_data, rxrdy, perr, ferr, ovf, busy,
        output rd_ack
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Load/reload down-counter; btu marks the clock where the count has reached zero.
module uart_bit_timer #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    input  logic [DIV_W-1:0] reload_val,
    output logic             btu
);

    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= (cnt_reg == '0) ? reload_val : cnt_reg - DIV_W'(1);
        end
    end

    assign btu = en && (cnt_reg == '0);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling, word assembly,
// parity/framing checks and a host ready/ack handshake with overflow flag.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    input  logic [DIV_W-1:0]        baud_div,
    input  logic                    eight,
    input  logic                    pen,
    input  logic                    ohel,
    uart_rx_frame_ctrl_if.master    host
);

    rx_state_t              state_reg;
    rx_cfg_t                cfg_reg;
    logic [3:0]             bitcnt_reg;
    logic [8:0]             sreg_reg;
    logic                   done_reg;
    logic                   stop_reg;
    logic                   busy_reg;
    logic [UART_WORD_W-1:0] data_reg;
    logic                   rxrdy_reg;
    logic                   perr_reg;
    logic                   ferr_reg;
    logic                   ovf_reg;

    logic                   btu;
    logic                   timer_load;
    logic                   timer_en;
    logic [DIV_W-1:0]       half_div;
    logic [DIV_W-1:0]       full_div;
    logic [3:0]             shift_n;
    logic [8:0]             aligned;
    logic [UART_WORD_W-1:0] word;
    logic                   pbit;

    assign timer_load = (state_reg == IDLE) && !rx;
    assign timer_en   = (state_reg != IDLE);
    assign half_div   = (baud_div >> 1) - DIV_W'(1);
    assign full_div   = baud_div - DIV_W'(1);

    uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk        (clk),
        .srst       (reset),
        .load       (timer_load),
        .load_val   (half_div),
        .en         (timer_en),
        .reload_val (full_div),
        .btu        (btu)
    );

    // Bits enter at the MSB, so after N shifts the frame sits in the top N bits.
    assign shift_n = 4'd7 + {3'b000, cfg_reg.eight} + {3'b000, cfg_reg.pen};
    assign aligned = sreg_reg >> (4'd9 - shift_n);
    assign word    = cfg_reg.eight ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign pbit    = cfg_reg.eight ? aligned[8] : aligned[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cfg_reg    <= '0;
            bitcnt_reg <= '0;
            sreg_reg   <= '0;
            done_reg   <= 1'b0;
            stop_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            data_reg   <= '0;
            rxrdy_reg  <= 1'b0;
            perr_reg   <= 1'b0;
            ferr_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!rx) begin
                        state_reg <= START;
                        busy_reg  <= 1'b1;
                        cfg_reg   <= '{eight, pen, ohel};
                    end
                end
                START: begin
                    if (btu) begin
                        if (rx) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg  <= DATA;
                            bitcnt_reg <= '0;
                        end
                    end
                end
                DATA: begin
                    if (btu) begin
                        sreg_reg   <= {rx, sreg_reg[8:1]};
                        bitcnt_reg <= bitcnt_reg + 4'd1;
                        if (bitcnt_reg == shift_n - 4'd1) begin
                            state_reg <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Re-arm at mid-stop; the word is published on the following edge.
                    if (btu) begin
                        stop_reg  <= rx;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            if (done_reg) begin
                data_reg  <= word;
                perr_reg  <= parity_err(word, pbit, cfg_reg);
                ferr_reg  <= ~stop_reg;
                rxrdy_reg <= 1'b1;
                ovf_reg   <= rxrdy_reg & ~host.rd_ack;
            end else if (host.rd_ack && rxrdy_reg) begin
                rxrdy_reg <= 1'b0;
                perr_reg  <= 1'b0;
                ferr_reg  <= 1'b0;
                ovf_reg   <= 1'b0;
            end
        end
    end

    assign host.rx_data = data_reg;
    assign host.rxrdy   = rxrdy_reg;
    assign host.perr    = perr_reg;
    assign host.ferr    = ferr_reg;
    assign host.ovf     = ovf_reg;
    assign host.busy    = busy_reg;

endmodule
